// File: rtl/alpha2_3_wb_guard_bridge.sv
// Registered Wishbone guard stage between the management-SoC master and the
// user-project peripherals. Mapped requests are forwarded downstream from
// registered copies. Unmapped requests and stalled downstream cycles are
// answered locally with ERR_DATA, and every such event is counted.
//
// state | meaning
// IDLE  | waiting for an upstream cyc & stb; decode the address
// REQ   | downstream cycle in flight, wait counter running
// RESP  | one-cycle upstream ack carrying the captured read data
module alpha2_3_wb_guard_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_PAGES = 2,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic [3:0]  s_sel_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  input  logic        err_clr_i,
  output logic        err_irq_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [19:0] BASE_PAGE = BASE_ADDR[31:12];
  localparam logic [19:0] PAGES     = 20'(NUM_PAGES);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] m_adr_q, m_adr_d;
  logic [31:0] m_dat_q, m_dat_d;
  logic [3:0]  m_sel_q, m_sel_d;
  logic        m_we_q, m_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_irq_q, err_irq_d;

  logic [19:0] page_off;
  logic        is_mapped;
  logic        err_event;
  logic        in_req;

  // Page offset relative to the window base; wraps below the base so those
  // addresses land far outside the window.
  always_comb begin
    page_off  = s_adr_i[31:12] - BASE_PAGE;
    is_mapped = (page_off < PAGES);
  end

  // Next-state logic and request latching.
  always_comb begin
    state_d    = state_q;
    m_adr_d    = m_adr_q;
    m_dat_d    = m_dat_q;
    m_sel_d    = m_sel_q;
    m_we_d     = m_we_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    err_event  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          if (is_mapped) begin
            // Only mapped requests touch the downstream copies, so rejected
            // write data never appears on m_dat_o.
            m_adr_d    = s_adr_i;
            m_dat_d    = s_dat_i;
            m_sel_d    = s_sel_i;
            m_we_d     = s_we_i;
            wait_cnt_d = 16'd0;
            state_d    = ST_REQ;
          end else begin
            rdata_d   = ERR_DATA;
            err_event = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        // Abort has priority: with the master gone there is nobody to answer.
        if (!s_cyc_i) begin
          state_d = ST_IDLE;
        end else if (m_ack_i) begin
          rdata_d = m_dat_i;
          state_d = ST_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          rdata_d   = ERR_DATA;
          err_event = 1'b1;
          state_d   = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Error counter: a clear coinciding with a new error leaves that error counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_irq_d = err_irq_q;
    if (err_clr_i && err_event) begin
      err_cnt_d = 8'd1;
      err_irq_d = 1'b1;
    end else if (err_clr_i) begin
      err_cnt_d = 8'd0;
      err_irq_d = 1'b0;
    end else if (err_event) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      err_irq_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      m_adr_q    <= 32'd0;
      m_dat_q    <= 32'd0;
      m_sel_q    <= 4'd0;
      m_we_q     <= 1'b0;
      rdata_q    <= 32'd0;
      wait_cnt_q <= 16'd0;
      err_cnt_q  <= 8'd0;
      err_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_adr_q    <= m_adr_d;
      m_dat_q    <= m_dat_d;
      m_sel_q    <= m_sel_d;
      m_we_q     <= m_we_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_irq_q  <= err_irq_d;
    end
  end

  // Strobes decode straight from the state flop so an async reset drops them at once.
  always_comb begin
    in_req    = (state_q == ST_REQ);
    m_cyc_o   = in_req;
    m_stb_o   = in_req;
    m_we_o    = m_we_q & in_req;
    m_adr_o   = m_adr_q;
    m_dat_o   = m_dat_q;
    m_sel_o   = m_sel_q;
    s_ack_o   = (state_q == ST_RESP);
    s_dat_o   = (state_q == ST_RESP) ? rdata_q : 32'd0;
    err_cnt_o = err_cnt_q;
    err_irq_o = err_irq_q;
  end

endmodule
